// File: rtl/aes_pkg.sv
// Shared AES-128 definitions for the key-schedule slice: state encoding,
// schedule constants, byte/word types and the GF(2^8) doubling helper.
package aes_pkg;

    typedef logic [7:0]  byte_t;
    typedef logic [31:0] word_t;

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    localparam byte_t      RCON_INIT  = 8'h01;
    localparam logic [3:0] NUM_ROUNDS = 4'd10;

    function automatic byte_t xtime(input byte_t b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

endpackage

// File: rtl/aes_sbox_comb.sv
// Purely combinational AES forward S-box (one byte). No register stage, so it
// can sit inside a single-cycle key or round datapath.
module aes_sbox_comb
    import aes_pkg::*;
(
    input  logic [7:0] in_byte,
    output logic [7:0] out_byte
);

    // Entry for input x occupies bits [2047-8x -: 8]; row-major from 8'h00.
    localparam logic [2047:0] SBOX_TABLE = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    always_comb begin
        out_byte = SBOX_TABLE[{~in_byte, 3'b111} -: 8];
    end

endmodule

// File: rtl/aes_round_key_gen.sv
// Iterative AES-128 key schedule: expands the cipher key one round per
// accepted handshake and streams round keys 0..10 to AddRoundKey.
module aes_round_key_gen
    import aes_pkg::*;
(
    input  logic         clk,
    input  logic         reset,
    input  logic [127:0] key_in,
    input  logic         key_load,
    output logic         busy,
    output logic [127:0] rk_out,
    output logic [3:0]   rk_round,
    output logic         rk_valid,
    input  logic         rk_ready,
    output logic         done
);

    state_t       state_q, state_d;
    logic [127:0] rk_q, rk_d;
    logic [3:0]   round_q, round_d;
    byte_t        rcon_q, rcon_d;
    logic         done_q, done_d;

    word_t w0, w1, w2, w3;
    word_t rot_w3, sub_w3, t_word;
    word_t n0, n1, n2, n3;

    assign w0     = rk_q[127:96];
    assign w1     = rk_q[95:64];
    assign w2     = rk_q[63:32];
    assign w3     = rk_q[31:0];
    assign rot_w3 = {w3[23:0], w3[31:24]};

    for (genvar i = 0; i < 4; i++) begin : g_subword
        aes_sbox_comb u_sbox (
            .in_byte  (rot_w3[8*i +: 8]),
            .out_byte (sub_w3[8*i +: 8])
        );
    end

    always_comb begin
        t_word = sub_w3 ^ {rcon_q, 24'h0};
        n0     = w0 ^ t_word;
        n1     = n0 ^ w1;
        n2     = n1 ^ w2;
        n3     = n2 ^ w3;
    end

    always_comb begin
        state_d = state_q;
        rk_d    = rk_q;
        round_d = round_q;
        rcon_d  = rcon_q;
        done_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (key_load) begin
                    state_d = RUN;
                    rk_d    = key_in;
                    round_d = '0;
                    rcon_d  = RCON_INIT;
                end
            end
            RUN: begin
                // Stalled handshakes fall through, holding every register.
                if (rk_ready) begin
                    if (round_q == NUM_ROUNDS) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else begin
                        rk_d    = {n0, n1, n2, n3};
                        round_d = round_q + 4'd1;
                        rcon_d  = xtime(rcon_q);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            rk_q    <= '0;
            round_q <= '0;
            rcon_q  <= RCON_INIT;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            rk_q    <= rk_d;
            round_q <= round_d;
            rcon_q  <= rcon_d;
            done_q  <= done_d;
        end
    end

    assign busy     = (state_q == RUN);
    assign rk_valid = (state_q == RUN);
    assign rk_out   = rk_q;
    assign rk_round = round_q;
    assign done     = done_q;

endmodule

// File: tb/tb_aes_round_key_gen.sv
// Bench for aes_round_key_gen: an arithmetic GF(2^8) key-expansion model is
// checked against the DUT every cycle, plus directed FIPS-197 vectors.
module tb_aes_round_key_gen;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic [127:0] key_in = '0;
    logic         key_load = 1'b0;
    logic         rk_ready = 1'b0;
    logic         busy;
    logic [127:0] rk_out;
    logic [3:0]   rk_round;
    logic         rk_valid;
    logic         done;

    localparam logic [127:0] FIPS_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] FIPS_R1   = 128'ha0fafe1788542cb123a339392a6c7605;
    localparam logic [127:0] FIPS_R10  = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] ZERO_R1   = 128'h62636363626363636263636362636363;
    localparam logic [127:0] ZERO_R10  = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;
    localparam logic [127:0] OTHER_KEY = 128'h000102030405060708090a0b0c0d0e0f;

    always #5 clk = ~clk;

    aes_round_key_gen dut (
        .clk      (clk),
        .reset    (reset),
        .key_in   (key_in),
        .key_load (key_load),
        .busy     (busy),
        .rk_out   (rk_out),
        .rk_round (rk_round),
        .rk_valid (rk_valid),
        .rk_ready (rk_ready),
        .done     (done)
    );

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model (field arithmetic, no tables) ----------
    function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
        logic [7:0] a, b, p;
        a = a_in; b = b_in; p = 8'h00;
        for (int unsigned i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            a = a[7] ? ({a[6:0], 1'b0} ^ 8'h1b) : {a[6:0], 1'b0};
            b = b >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] v, input int unsigned n);
        return (v << n) | (v >> (8 - n));
    endfunction

    function automatic logic [7:0] sbox_model(input logic [7:0] x);
        logic [7:0] inv;
        inv = 8'h00;
        for (int unsigned y = 1; y < 256; y++)
            if (gmul(x, 8'(y)) == 8'h01) inv = 8'(y);
        return inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    endfunction

    function automatic logic [127:0] model_rk(input logic [127:0] key, input logic [3:0] r);
        logic [31:0] w [4];
        logic [31:0] t;
        logic [7:0]  rc;
        for (int unsigned j = 0; j < 4; j++) w[j] = key[127 - 32*j -: 32];
        rc = 8'h01;
        for (int unsigned i = 1; i <= r; i++) begin
            t = {sbox_model(w[3][23:16]), sbox_model(w[3][15:8]),
                 sbox_model(w[3][7:0]),   sbox_model(w[3][31:24])};
            t = t ^ {rc, 24'h0};
            w[0] = w[0] ^ t;
            w[1] = w[1] ^ w[0];
            w[2] = w[2] ^ w[1];
            w[3] = w[3] ^ w[2];
            rc = gmul(rc, 8'h02);
        end
        return {w[0], w[1], w[2], w[3]};
    endfunction

    bit           m_active = 1'b0;
    logic [3:0]   m_round  = '0;
    logic [127:0] m_key    = '0;
    logic [127:0] m_rk     = '0;
    logic         m_done   = 1'b0;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_active = 1'b0;
            m_round  = '0;
            m_rk     = '0;
            m_done   = 1'b0;
        end else begin
            m_done = 1'b0;
            if (!m_active) begin
                if (key_load) begin
                    m_active = 1'b1;
                    m_key    = key_in;
                    m_round  = '0;
                end
            end else if (rk_ready) begin
                if (m_round == 4'd10) begin
                    m_active = 1'b0;
                    m_done   = 1'b1;
                end else begin
                    m_round = m_round + 4'd1;
                end
            end
            if (m_active) m_rk = model_rk(m_key, m_round);
        end
    end

    always @(negedge clk) begin
        chk("cmp_busy",     128'(busy),     128'(m_active));
        chk("cmp_rk_valid", 128'(rk_valid), 128'(m_active));
        chk("cmp_rk_round", 128'(rk_round), 128'(m_round));
        chk("cmp_rk_out",   rk_out,         m_rk);
        chk("cmp_done",     128'(done),     128'(m_done));
    end

    // ---------------- directed stimulus --------------------------------------
    task automatic step();
        @(negedge clk);
        #2;
    endtask

    // Returns in the cycle after acceptance (round 0 presented).
    task automatic load_key(input logic [127:0] k);
        step();
        key_in   = k;
        key_load = 1'b1;
        step();
        key_load = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, got running expected finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned hs;
        bit          finished;

        #1 reset = 1'b0;
        step();
        step();
        chk("reset_busy",  128'(busy),     128'd0);
        chk("reset_valid", 128'(rk_valid), 128'd0);
        chk("reset_round", 128'(rk_round), 128'd0);
        chk("reset_rk",    rk_out,         128'd0);
        chk("reset_done",  128'(done),     128'd0);
        reset = 1'b1;

        chk("model_fips_r1",  model_rk(FIPS_KEY, 4'd1),  FIPS_R1);
        chk("model_fips_r10", model_rk(FIPS_KEY, 4'd10), FIPS_R10);
        chk("model_zero_r1",  model_rk('0, 4'd1),        ZERO_R1);
        chk("model_zero_r10", model_rk('0, 4'd10),       ZERO_R10);

        // FIPS key, no backpressure, exact latency
        rk_ready = 1'b1;
        load_key(FIPS_KEY);
        chk("fips_r0",       rk_out, FIPS_KEY);
        chk("fips_r0_valid", 128'(rk_valid), 128'd1);
        step();
        chk("fips_r1", rk_out, FIPS_R1);
        repeat (9) step();
        chk("fips_r10",       rk_out,         FIPS_R10);
        chk("fips_r10_round", 128'(rk_round), 128'd10);
        step();
        chk("fips_done",      128'(done), 128'd1);
        chk("fips_busy_fall", 128'(busy), 128'd0);

        // key_load coincident with done starts the all-zero schedule
        key_in   = '0;
        key_load = 1'b1;
        step();
        key_load = 1'b0;
        chk("coinc_round0", 128'(rk_round), 128'd0);
        chk("coinc_valid",  128'(rk_valid), 128'd1);
        chk("zero_r0",      rk_out,         128'd0);
        step();
        chk("zero_r1", rk_out, ZERO_R1);
        repeat (9) step();
        chk("zero_r10", rk_out, ZERO_R10);
        step();
        chk("zero_done", 128'(done), 128'd1);

        // key_load during RUN must be ignored
        load_key(FIPS_KEY);
        repeat (3) step();
        key_in   = OTHER_KEY;
        key_load = 1'b1;
        step();
        key_load = 1'b0;
        repeat (6) step();
        chk("midload_r10", rk_out, FIPS_R10);
        step();
        chk("midload_done", 128'(done), 128'd1);

        // random backpressure on the FIPS key
        rk_ready = 1'b0;
        load_key(FIPS_KEY);
        hs       = 0;
        finished = 1'b0;
        for (int unsigned cyc = 0; cyc < 400 && !finished; cyc++) begin
            rk_ready = 1'($urandom_range(0, 1));
            if (rk_valid && rk_ready) hs++;
            step();
            if (done) finished = 1'b1;
        end
        chk("bp_done_seen",  128'(finished), 128'd1);
        chk("bp_handshakes", 128'(hs),       128'd11);
        chk("bp_last_key",   rk_out,         FIPS_R10);

        // reset at round 5, then restart
        rk_ready = 1'b1;
        load_key('0);
        repeat (5) step();
        chk("rst_at_round5", 128'(rk_round), 128'd5);
        reset = 1'b0;
        step();
        chk("rst_busy",  128'(busy),     128'd0);
        chk("rst_valid", 128'(rk_valid), 128'd0);
        chk("rst_round", 128'(rk_round), 128'd0);
        reset = 1'b1;
        load_key(FIPS_KEY);
        chk("restart_r0",    rk_out,         FIPS_KEY);
        chk("restart_round", 128'(rk_round), 128'd0);
        repeat (11) step();
        chk("restart_done", 128'(done), 128'd1);

        rk_ready = 1'b0;
        repeat (3) step();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
